// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_div_q16 signed fixed-point divider.
package seq_div_pkg;

  localparam int unsigned IN_W_DEF      = 15;
  localparam int unsigned FRAC_BITS_DEF = 16;
  localparam int unsigned OUT_W_DEF     = 32;

  localparam int unsigned DIV_ITER = IN_W_DEF + FRAC_BITS_DEF;

  localparam logic [OUT_W_DEF-1:0] POS_SAT = 32'h7FFF_FFFF;
  localparam logic [OUT_W_DEF-1:0] NEG_SAT = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StSign,
    StZero,
    StDone
  } state_e;

endpackage

// File: rtl/seq_div_q16_if.sv
// Request/response bundle between a numerator/denominator requester and seq_div_q16.
interface seq_div_q16_if #(
  parameter int unsigned IN_W  = 15,
  parameter int unsigned OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  dataa;
  logic [IN_W-1:0]  datab;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic             divbyzero;

  modport master (
    output in_valid, dataa, datab, out_ready,
    input  in_ready, out_valid, result, divbyzero
  );

  modport slave (
    input  in_valid, dataa, datab, out_ready,
    output in_ready, out_valid, result, divbyzero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         bit_in,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;

  assign shifted  = {rem, bit_in};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? W'(shifted - {1'b0, divisor}) : W'(shifted);

endmodule

// File: rtl/seq_div_q16.sv
// Iterative signed divider returning a Q16.16 quotient and a divide-by-zero flag.
// Define SEQ_DIV_ROUND_EN for round-half-away-from-zero (one extra guard iteration).
module seq_div_q16
  import seq_div_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  seq_div_q16_if.slave  bus
);

  localparam int unsigned DivW = IN_W + FRAC_BITS;
`ifdef SEQ_DIV_ROUND_EN
  localparam int unsigned Iter = DivW + 1;
`else
  localparam int unsigned Iter = DivW;
`endif
  localparam int unsigned CntW = $clog2(Iter + 1);
  localparam int unsigned RemW = IN_W + 1;

  localparam logic [OUT_W-1:0] PosSat = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NegSat = {1'b1, {(OUT_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Iter-1:0]   dvd_q, dvd_d;
  logic [Iter-1:0]   quo_q, quo_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [IN_W-1:0]   dvs_q, dvs_d;
  logic              sign_q, sign_d;
  logic              neg_a_q, neg_a_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              dbz_q, dbz_d;
  logic              ovalid_q, ovalid_d;

  logic [IN_W-1:0]   abs_a, abs_b;
  logic [RemW-1:0]   step_rem;
  logic              step_q;
  logic [DivW-1:0]   mag;
  logic [OUT_W-1:0]  mag_ext;

  assign abs_a = bus.dataa[IN_W-1] ? -bus.dataa : bus.dataa;
  assign abs_b = bus.datab[IN_W-1] ? -bus.datab : bus.datab;

`ifdef SEQ_DIV_ROUND_EN
  // Guard bit is the first discarded fraction bit; adding it rounds half away from zero.
  assign mag = quo_q[Iter-1:1] + DivW'(quo_q[0]);
`else
  assign mag = quo_q;
`endif
  assign mag_ext = OUT_W'(mag);

  div_step #(
    .W (RemW)
  ) u_div_step (
    .rem      (rem_q),
    .divisor  (RemW'(dvs_q)),
    .bit_in   (dvd_q[Iter-1]),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    sign_d   = sign_q;
    neg_a_d  = neg_a_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ovalid_d = ovalid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d  = bus.dataa[IN_W-1] ^ bus.datab[IN_W-1];
          neg_a_d = bus.dataa[IN_W-1];
          dvs_d   = abs_b;
          // Numerator magnitude pre-shifted by FRAC_BITS (plus guard slot when rounding).
          dvd_d   = Iter'(abs_a) << (Iter - IN_W);
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = CntW'(Iter);
          state_d = (bus.datab == '0) ? StZero : StCalc;
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[Iter-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StSign;
        end
      end
      StSign: begin
        result_d = sign_q ? -mag_ext : mag_ext;
        dbz_d    = 1'b0;
        ovalid_d = 1'b1;
        state_d  = StDone;
      end
      StZero: begin
        result_d = neg_a_q ? NegSat : PosSat;
        dbz_d    = 1'b1;
        ovalid_d = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      sign_q   <= 1'b0;
      neg_a_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      sign_q   <= sign_d;
      neg_a_q  <= neg_a_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = ovalid_q;
  assign bus.result    = result_q;
  assign bus.divbyzero = dbz_q;

endmodule

// File: doc/seq_div_q16.md
Name: seq_div_q16

Overview:
- Iterative signed fixed-point divider. It is the responder side of the numerator/denominator request issued by the edge-parameter compute stages (a, b, c terms).
- Accepts one signed numerator/denominator pair via valid/ready and returns a signed Q16.16 quotient plus a divide-by-zero flag.
- Radix-2 restoring algorithm on magnitudes, sign fixed at the end; one division in flight at a time.

Parameters:
- IN_W, 15, width of signed numerator and denominator (two's complement)
- FRAC_BITS, 16, fractional bits of result
- OUT_W, 32, result width; must satisfy OUT_W >= IN_W + FRAC_BITS + 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- dataa  in  IN_W  signed numerator
- datab  in  IN_W  signed denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  OUT_W  signed quotient, Q(OUT_W-FRAC_BITS).FRAC_BITS
- divbyzero  out  1  current result came from datab == 0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low. Everything else is synchronous to the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, result=0, divbyzero=0, state=IDLE, all iteration registers 0.
- Reset asserted mid-operation aborts the division immediately. No result is emitted after release.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch sign = dataa[MSB]^datab[MSB], |dataa|, |datab|, and dataa sign.
    - datab==0 -> ZERO; else -> CALC, with iteration counter = IN_W+FRAC_BITS (31).
  - CALC:
    - Each cycle, shift the dividend (|dataa| << FRAC_BITS, 31 bits) MSB into the partial remainder.
    - Trial-subtract |datab|. If non-negative, keep the difference and shift in a quotient bit of 1; else shift in 0.
    - Counter decrements; on 0 -> SIGN.
  - SIGN:
    - result = sign ? -quotient : quotient, zero-extended magnitude to OUT_W first.
    - divbyzero=0, out_valid=1 -> DONE.
  - ZERO:
    - divbyzero=1, out_valid=1.
    - result = 32'h8000_0000 if dataa negative, else 32'h7FFF_FFFF (dataa==0 gives the positive saturation).
    - -> DONE.
  - DONE:
    - Hold result, divbyzero and out_valid stable while out_ready=0.
    - On out_valid&out_ready: out_valid=0 -> IDLE.
    - in_ready returns to 1 the next cycle.
- Latency, counted from the accepting edge:
  - Normal: out_valid high after 33 edges (31 CALC + SIGN + DONE entry).
  - Divide-by-zero: out_valid high after 2 edges.
- Throughput: one result per 34 cycles minimum with out_ready tied high.
- in_ready=0 in every state except IDLE; in_valid is ignored there.
- Arithmetic:
  - Magnitude of the most negative input (-2^(IN_W-1)) is 2^(IN_W-1), held in IN_W bits unsigned.
  - Maximum quotient magnitude is 2^(IN_W-1+FRAC_BITS) = 2^30 and fits OUT_W. No saturation is needed except the ZERO case.
- Rounding: truncation toward zero. The remainder is discarded.
- Zero numerator with nonzero denominator gives result 0 and divbyzero 0.

Optional Feature:
- Macro: SEQ_DIV_ROUND_EN.
- Defined:
  - One extra CALC iteration (counter starts at IN_W+FRAC_BITS+1) produces a guard bit.
  - SIGN adds the guard bit to the magnitude before negation: round half away from zero.
  - Normal latency becomes 34 edges.
- Undefined: truncation toward zero as above; latency 33.
- ZERO-state behaviour is identical either way.

Decomposition:
- Shared package seq_div_pkg holds:
  - state encoding typedef (IDLE, CALC, SIGN, ZERO, DONE);
  - localparams DIV_ITER = IN_W+FRAC_BITS and POS_SAT/NEG_SAT constants.
- One natural sub-module, div_step: a combinational restoring step.
  - Inputs: partial remainder, divisor, incoming bit.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- dataa=100, datab=20, out_ready=1 -> result 0x0005_0000, divbyzero 0, out_valid exactly 33 cycles after accept.
- dataa=-30, datab=8 -> result 0xFFFC_4000 (-3.75); dataa=30, datab=-8 -> same value.
- dataa=2, datab=3:
  - default build -> 0x0000_AAAA;
  - SEQ_DIV_ROUND_EN build -> 0x0000_AAAB with 34-cycle latency.
- datab=0:
  - dataa=5 -> 0x7FFF_FFFF, divbyzero 1, out_valid 2 cycles after accept;
  - dataa=-5 -> 0x8000_0000.
- dataa=-16384, datab=1 -> 0xC000_0000. Then hold out_ready=0 for 10 cycles -> result/out_valid stable, in_ready=0, a new in_valid is ignored.
- Assert rst low at CALC cycle 10 -> all outputs at reset values asynchronously; after release in_ready=1, no stale out_valid; next request (7/7) -> 0x0001_0000.
